mem_writeback_stage: RTL and testbench
======================================

# mem_writeback_stage

Registered memory-access / write-back stage of the 4-stage RISC-V core, directly downstream of the execute unit. Accepts one retired-execute result per handshake, performs RV32I loads/stores (byte, half, word) against the data RAM through a req/ack port, formats load data, and drives the single register-file write port. Back-pressures execute while a memory transaction is outstanding and flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- ADDR_W, 10, data-RAM word-address width
- TIMEOUT, 16, max cycles mem_req may wait for mem_ack (≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute result present
- ex_ready  out  1  stage can accept; = (state==IDLE) & ~Reset
- ex_is_load  in  1  instruction is a load
- ex_is_store  in  1  instruction is a store
- ex_reg_write  in  1  instruction writes rd (non-memory ops)
- ex_rd  in  5  destination register
- ex_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_result  in  32  ALU result (byte address for mem ops, write-back value otherwise)
- ex_store_data  in  32  rs2 value for stores
- mem_req  out  1  data RAM request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  word address = ex_result[ADDR_W+1:2]
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_ack  in  1  transaction complete; mem_rdata valid same cycle for loads
- mem_rdata  in  32  read word
- rf_we  out  1  register-file write strobe
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- misalign_err  out  1  one-cycle pulse: misaligned or illegal funct3
- bus_err  out  1  one-cycle pulse: ack timeout

## Operation
- States: IDLE, MEM. Accept = ex_valid & ex_ready.
- IDLE, accept, non-memory: if ex_reg_write & ex_rd≠0, next cycle rf_we=1, rf_waddr=ex_rd, rf_wdata=ex_result. Stay IDLE.
- IDLE, accept, load/store: check alignment (H: addr[0]=0; W: addr[1:0]=0) and funct3 legality (stores: 000/001/010; loads: 000/001/010/100/101). Fail → misalign_err pulse next cycle, no mem_req, no rf write, stay IDLE. Pass → latch rd, funct3, offset, is_load; register mem_req=1, mem_we, mem_addr, mem_wdata, mem_wstrb; go MEM; clear timeout counter.
- Store lanes: SB wdata={4{d[7:0]}}, wstrb=0001<<off; SH wdata={2{d[15:0]}}, wstrb=0011<<off; SW wdata=d, wstrb=1111. Loads: wstrb=0000, mem_we=0.
- ex_is_load & ex_is_store both 1: treated as illegal → misalign_err.
- MEM: ex_ready=0; mem_req and all mem_* outputs stable. On mem_ack: drop mem_req next edge, go IDLE; load → rf_we next cycle with extracted lane, sign-extended (B/H) or zero-extended (BU/HU); rd=0 suppresses rf_we. Store → no rf write.
- Timeout: counter increments each MEM cycle without ack; when it reaches TIMEOUT-1 with no ack, next edge: mem_req=0, bus_err pulse, go IDLE, no rf write.
- rf_we, misalign_err, bus_err are single-cycle pulses; rf_waddr/rf_wdata hold last value otherwise.

## Timing
- Reset (sampled on edge): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, rf_we=0, rf_waddr=0, rf_wdata=0, misalign_err=0, bus_err=0, counter=0. ex_ready=0 while Reset high.
- Reset mid-MEM: transaction abandoned, mem_req low after that edge, no rf write, no error pulse.
- Non-memory latency: 1 cycle accept→rf_we; back-to-back accepts every cycle.
- Memory: accept at edge N → mem_req high from N+1. Ack sampled at edge N+k (k≥1) → mem_req low and rf_we (loads) at N+k+1; ex_ready high in cycle N+k+1, next accept at edge N+k+1 at earliest.
- mem_ack ignored when mem_req=0.
- Ack on the same edge the timeout would fire: ack wins, no bus_err.

## Test plan
- ALU op: ex_result=0x1234_5678, rd=5, reg_write → rf_we pulse next cycle, waddr=5, wdata=0x12345678; rd=0 → no rf_we.
- LB addr 0x103, mem_rdata=0x80_00_00_00, ack after 3 cycles → mem_addr=0x040, rf_wdata=0xFFFF_FF80; LBU same → 0x0000_0080; ex_ready low for 3 cycles.
- SH addr 0x202, data 0xAAAA_BEEF, zero-wait ack → wdata=0xBEEF_BEEF, wstrb=1100, mem_we=1, no rf_we.
- LW addr 0x101 → misalign_err pulse, mem_req never asserts, ex_ready stays high.
- Load with ack withheld, TIMEOUT=16 → mem_req high exactly 16 cycles, bus_err pulse, no rf_we; then ack at cycle 16 instead → load completes, no bus_err.
- Reset asserted during MEM wait → mem_req low next edge, all outputs at reset values, later ack ignored.

Source files
------------

// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage: RV32I memory-access / write-back stage with req/ack data-RAM port,
// load lane formatting, misalignment detection and ack timeout.
module mem_writeback_stage #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_rd,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_result,
    input  logic [31:0]       ex_store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              misalign_err,
    output logic              bus_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MEM  = 1'b1;
    localparam int         CW   = $clog2(TIMEOUT);

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_rd;
    logic [2:0]    r_funct3;
    logic [1:0]    r_off;
    logic          r_is_load;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_f3_ok;
    logic        w_align_ok;
    logic        w_mem_ok;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_strb;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic        w_timeout;

    assign ex_ready = (r_state == IDLE) & ~Reset;

    always_comb begin
        w_accept   = ex_valid & ex_ready;
        w_is_mem   = ex_is_load | ex_is_store;
        w_f3_ok    = (ex_is_load & ex_is_store) ? 1'b0 :
                     ex_is_store ? (ex_funct3 inside {3'b000, 3'b001, 3'b010}) :
                                   (ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        w_align_ok = (ex_funct3[1:0] == 2'b01) ? ~ex_result[0] :
                     (ex_funct3[1:0] == 2'b10) ? (ex_result[1:0] == 2'b00) : 1'b1;
        w_mem_ok   = w_f3_ok & w_align_ok;
        w_st_data  = (ex_funct3[1:0] == 2'b00) ? {4{ex_store_data[7:0]}} :
                     (ex_funct3[1:0] == 2'b01) ? {2{ex_store_data[15:0]}} : ex_store_data;
        w_st_strb  = (ex_funct3[1:0] == 2'b00) ? 4'b0001 << ex_result[1:0] :
                     (ex_funct3[1:0] == 2'b01) ? 4'b0011 << ex_result[1:0] : 4'b1111;
        // Bring the addressed lane down to bit 0 before sign/zero extension.
        w_shift    = mem_rdata >> {r_off, 3'b000};
        w_load     = (r_funct3 == 3'b000) ? {{24{w_shift[7]}}, w_shift[7:0]} :
                     (r_funct3 == 3'b001) ? {{16{w_shift[15]}}, w_shift[15:0]} :
                     (r_funct3 == 3'b100) ? {24'd0, w_shift[7:0]} :
                     (r_funct3 == 3'b101) ? {16'd0, w_shift[15:0]} : mem_rdata;
        w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rd         <= '0;
            r_funct3     <= '0;
            r_off        <= '0;
            r_is_load    <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            rf_we        <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept && !w_is_mem) begin
                    if (ex_reg_write && ex_rd != 5'd0) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= ex_rd;
                        rf_wdata <= ex_result;
                    end
                end else if (w_accept && !w_mem_ok) begin
                    misalign_err <= 1'b1;
                end else if (w_accept) begin
                    r_rd      <= ex_rd;
                    r_funct3  <= ex_funct3;
                    r_off     <= ex_result[1:0];
                    r_is_load <= ex_is_load;
                    r_cnt     <= '0;
                    r_state   <= MEM;
                    mem_req   <= 1'b1;
                    mem_we    <= ex_is_store;
                    mem_addr  <= ex_result[ADDR_W+1:2];
                    mem_wdata <= w_st_data;
                    mem_wstrb <= ex_is_store ? w_st_strb : 4'b0000;
                end
            end else if (mem_ack) begin
                mem_req <= 1'b0;
                r_state <= IDLE;
                if (r_is_load && r_rd != 5'd0) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= r_rd;
                    rf_wdata <= w_load;
                end
            end else if (w_timeout) begin
                mem_req <= 1'b0;
                bus_err <= 1'b1;
                r_state <= IDLE;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_writeback_stage.sv
// tb_mem_writeback_stage: directed plan cases plus randomized ops checked against a
// transaction-level model of the memory/write-back stage.
module tb_mem_writeback_stage;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_is_load = 1'b0;
    logic        ex_is_store = 1'b0;
    logic        ex_reg_write = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_result = '0;
    logic [31:0] ex_store_data = '0;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        misalign_err;
    logic        bus_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    mem_writeback_stage #(.ADDR_W(10), .TIMEOUT(16)) dut (
        .clk(clk), .Reset(Reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
    endfunction

    task automatic drive(input logic ld, input logic st, input logic rw, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] res, input logic [31:0] sd);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_reg_write = rw;
        ex_rd = rd; ex_funct3 = f3; ex_result = res; ex_store_data = sd;
    endtask

    task automatic idle_cycle();
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_rf_we", rf_we, 0);
        check("idle_misalign", misalign_err, 0);
        check("idle_bus_err", bus_err, 0);
        check("idle_req", mem_req, 0);
        check("idle_rf_wdata", rf_wdata, m_wdata);
        check("idle_rf_waddr", rf_waddr, m_waddr);
    endtask

    // ack_k: edge (counted from first MEM cycle) at which ack is sampled; 0 = never
    task automatic run_op(input logic ld, input logic st, input logic rw, input logic [4:0] rd,
                          input logic [2:0] f3, input logic [31:0] res, input logic [31:0] sd,
                          input logic [31:0] rdata, input int ack_k);
        int          sz;
        int          off;
        bit          legal;
        logic [31:0] v;
        logic [31:0] exp_w;
        logic [3:0]  exp_s;
        @(negedge clk);
        check("ready_before", ex_ready, 1);
        drive(ld, st, rw, rd, f3, res, sd);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        if (!ld && !st) begin
            if (rw && rd != 0) begin m_waddr = rd; m_wdata = res; end
            check("alu_rf_we", rf_we, rw && rd != 0);
            check("alu_waddr", rf_waddr, m_waddr);
            check("alu_wdata", rf_wdata, m_wdata);
            check("alu_req", mem_req, 0);
            check("alu_ready", ex_ready, 1);
        end else begin
            sz = op_size(f3);
            off = int'(res[1:0]);
            legal = !(ld && st) && sz != 0 && !(st && f3 > 3'd2);
            if (legal && (int'(res[1:0]) % sz) != 0) legal = 0;
            if (!legal) begin
                check("bad_misalign", misalign_err, 1);
                check("bad_req", mem_req, 0);
                check("bad_ready", ex_ready, 1);
                check("bad_rf_we", rf_we, 0);
            end else begin
                check("acc_req", mem_req, 1);
                check("acc_we", mem_we, st);
                check("acc_addr", mem_addr, res[11:2]);
                check("acc_ready", ex_ready, 0);
                check("acc_misalign", misalign_err, 0);
                if (st) begin
                    exp_s = (sz == 4) ? 4'hF : 4'((sz == 2 ? 3 : 1) << off);
                    exp_w = (sz == 1) ? sd[7:0] * 32'h0101_0101 : (sz == 2) ? sd[15:0] * 32'h0001_0001 : sd;
                    check("st_wstrb", mem_wstrb, exp_s);
                    check("st_wdata", mem_wdata, exp_w);
                end else begin
                    check("ld_wstrb", mem_wstrb, 0);
                end
                for (int k = 1; k <= 16; k++) begin
                    mem_ack = (k == ack_k);
                    mem_rdata = (k == ack_k) ? rdata : $urandom;
                    @(posedge clk);
                    @(negedge clk);
                    mem_ack = 1'b0;
                    if (k == ack_k) begin
                        if (ld && rd != 0) begin
                            v = rdata >> (8 * off);
                            v = (sz == 1) ? (v & 32'hFF) : (sz == 2) ? (v & 32'hFFFF) : v;
                            if (f3 == 3'd0 && v >= 128) v = v - 256;
                            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
                            m_waddr = rd;
                            m_wdata = v;
                        end
                        check("done_req", mem_req, 0);
                        check("done_rf_we", rf_we, ld && rd != 0);
                        check("done_waddr", rf_waddr, m_waddr);
                        check("done_wdata", rf_wdata, m_wdata);
                        check("done_bus_err", bus_err, 0);
                        check("done_ready", ex_ready, 1);
                        break;
                    end else if (k == 16) begin
                        check("to_req", mem_req, 0);
                        check("to_bus_err", bus_err, 1);
                        check("to_rf_we", rf_we, 0);
                        check("to_ready", ex_ready, 1);
                    end else begin
                        check("wait_req", mem_req, 1);
                        check("wait_ready", ex_ready, 0);
                        check("wait_bus_err", bus_err, 0);
                        check("wait_addr", mem_addr, res[11:2]);
                    end
                end
            end
        end
        idle_cycle();
    endtask

    logic [2:0] f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ex_ready, 0);
        check("rst_req", mem_req, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        Reset = 1'b0;

        run_op(0, 0, 1, 5'd5, 3'd0, 32'h1234_5678, 0, 0, 0);
        run_op(0, 0, 1, 5'd0, 3'd0, 32'hDEAD_BEEF, 0, 0, 0);
        run_op(1, 0, 0, 5'd7, 3'd0, 32'h103, 0, 32'h8000_0000, 3);
        run_op(1, 0, 0, 5'd8, 3'd4, 32'h103, 0, 32'h8000_0000, 3);
        run_op(0, 1, 0, 5'd0, 3'd1, 32'h202, 32'hAAAA_BEEF, 0, 1);
        run_op(1, 0, 0, 5'd9, 3'd2, 32'h101, 0, 0, 1);
        run_op(1, 0, 0, 5'd10, 3'd2, 32'h100, 0, 32'hCAFE_F00D, 0);
        run_op(1, 0, 0, 5'd11, 3'd2, 32'h104, 0, 32'hCAFE_F00D, 16);
        run_op(1, 1, 0, 5'd12, 3'd2, 32'h108, 0, 0, 1);

        // back-to-back ALU accepts
        @(negedge clk);
        drive(0, 0, 1, 5'd3, 3'd0, 32'h1111_1111, 0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_ready", ex_ready, 1);
        drive(0, 0, 1, 5'd4, 3'd0, 32'h2222_2222, 0);
        check("b2b1_rf_we", rf_we, 1);
        check("b2b1_wdata", rf_wdata, 32'h1111_1111);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        check("b2b2_rf_we", rf_we, 1);
        check("b2b2_waddr", rf_waddr, 5'd4);
        check("b2b2_wdata", rf_wdata, 32'h2222_2222);
        m_waddr = 5'd4;
        m_wdata = 32'h2222_2222;

        // reset while waiting for ack
        @(negedge clk);
        drive(1, 0, 0, 5'd6, 3'd2, 32'h3FC, 0);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        check("rm_req", mem_req, 1);
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rm_req_low", mem_req, 0);
        check("rm_ready", ex_ready, 0);
        check("rm_rf_we", rf_we, 0);
        check("rm_rf_wdata", rf_wdata, 0);
        check("rm_rf_waddr", rf_waddr, 0);
        check("rm_addr", mem_addr, 0);
        check("rm_wstrb", mem_wstrb, 0);
        check("rm_bus_err", bus_err, 0);
        Reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("rm_late_ack", rf_we, 0);
        check("rm_late_req", mem_req, 0);
        check("rm_late_ready", ex_ready, 1);
        m_waddr = '0;
        m_wdata = '0;

        for (int i = 0; i < 300; i++) begin
            int kind;
            int ak;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            ak = $urandom_range(1, 20);
            if (ak > 16) ak = 0;
            a = {20'd0, 12'($urandom)};
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if (kind < 3)
                run_op(0, 0, 1'($urandom), 5'($urandom), 3'($urandom), $urandom, 0, 0, 0);
            else
                run_op(kind < 7 || kind == 9, kind >= 7, 1'($urandom), 5'($urandom),
                       f3_tab[($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7)],
                       a, $urandom, $urandom, ak);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
